// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state and mode encodings for the mux_scan selector
package mux_scan_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_ptr.sv
// rtl/mux_scan_ptr.sv - channel pointer: manual load with range check, round-robin scan with dwell timeout
module mux_scan_ptr
  import mux_scan_pkg::*;
#(
  parameter  int N_CH    = 8,
  parameter  int DWELL_W = 4,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_load,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               capture,
  output logic [SEL_W-1:0]   cur_ch,
  output logic               adv_pulse
);

  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ptr_q, ptr_nxt, ptr_wrap;
  logic [DWELL_W-1:0] cnt_q, cnt_nxt, limit_m1;
  logic               timeout;

  // A dwell of 0 behaves as 1; >= lets a freshly lowered limit force an advance.
  assign limit_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign timeout  = (cnt_q >= limit_m1);
  assign ptr_wrap = (ptr_q == LAST_CH) ? '0 : ptr_q + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MANUAL;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      ptr_q <= ptr_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    adv_pulse = 1'b0;
    case (state)
      MANUAL: begin
        if (sel_load && ({1'b0, sel} < N_CH_EXT)) begin
          ptr_nxt = sel;
        end
        if (mode == MODE_SCAN) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      end
      SCAN: begin
        // Capture and timeout together collapse into one advance.
        if (capture || timeout) begin
          adv_pulse = 1'b1;
          ptr_nxt   = ptr_wrap;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + DWELL_W'(1);
        end
        if (mode == MODE_MANUAL) begin
          state_nxt = MANUAL;
        end
      end
    endcase
  end

  assign cur_ch = ptr_q;

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - N_CH:1 selector with registered valid/ready output; MUX_SCAN_PARITY_EN adds out_parity
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH    = 8,
  parameter  int W       = 8,
  parameter  int DWELL_W = 4,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_valid,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_load,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic                out_parity,
`endif
  input  logic                out_ready,
  output logic [SEL_W-1:0]    cur_ch
);

  logic [W-1:0] ch_data [N_CH];
  logic [W-1:0] sel_data;
  logic         capture;
  logic         adv_pulse;

  for (genvar k = 0; k < N_CH; k++) begin : g_slice
    assign ch_data[k] = in_data[k*W +: W];
  end

  assign sel_data = ch_data[cur_ch];
  assign capture  = (!out_valid || out_ready) && in_valid[cur_ch];

  mux_scan_ptr #(
    .N_CH    (N_CH),
    .DWELL_W (DWELL_W)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .sel_load  (sel_load),
    .dwell     (dwell),
    .capture   (capture),
    .cur_ch    (cur_ch),
    .adv_pulse (adv_pulse)
  );

  // A held word keeps data and channel frozen until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= sel_data;
      out_ch    <= cur_ch;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (capture) begin
      out_parity <= ^sel_data;
    end
  end
`endif

  // Every advance must move the pointer, since N_CH is at least 2.
  a_adv_moves : assert property (@(posedge clk) (rst_n && adv_pulse) |=> (!rst_n || cur_ch != $past(cur_ch)));

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - scoreboard bench for mux_scan (8-channel and 6-channel instances)
module tb_mux_scan;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic        mode;
  logic [2:0]  sel;
  logic        sel_load;
  logic [3:0]  dwell;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_parity;
  logic        out_ready;
  logic [2:0]  cur_ch;

  logic [47:0] s_in_data;
  logic [5:0]  s_in_valid;
  logic        s_mode;
  logic [2:0]  s_sel;
  logic        s_sel_load;
  logic [7:0]  s_out_data;
  logic [2:0]  s_out_ch;
  logic        s_out_valid;
  logic        s_out_parity;
  logic [2:0]  s_cur_ch;

  exp_t sb[$];
  exp_t e;
  int   n_checks;
  int   n_fail;

  mux_scan #(.N_CH(8), .W(8), .DWELL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .mode      (mode),
    .sel       (sel),
    .sel_load  (sel_load),
    .dwell     (dwell),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready),
    .cur_ch    (cur_ch)
  );

  mux_scan #(.N_CH(6), .W(8), .DWELL_W(4)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s_in_data),
    .in_valid  (s_in_valid),
    .mode      (s_mode),
    .sel       (s_sel),
    .sel_load  (s_sel_load),
    .dwell     (dwell),
    .out_data  (s_out_data),
    .out_ch    (s_out_ch),
    .out_valid (s_out_valid),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity(s_out_parity),
`endif
    .out_ready (1'b1),
    .cur_ch    (s_cur_ch)
  );

`ifndef MUX_SCAN_PARITY_EN
  assign out_parity   = 1'b0;
  assign s_out_parity = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_checks++; if (out_ch !== 3'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    n_checks++; if (cur_ch !== 3'd0) begin n_fail++; $display("FAIL reset_cur_ch: got %0d want 0", cur_ch); end
    n_checks++; if (s_cur_ch !== 3'd0) begin n_fail++; $display("FAIL reset_cur_ch6: got %0d want 0", s_cur_ch); end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    in_data[3*8 +: 8] = 8'hA5;
    sel = 3'd3; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    n_checks++; if (cur_ch !== 3'd3) begin n_fail++; $display("FAIL manual_load: got %0d want 3", cur_ch); end
    in_valid = 8'h08;
    sb.push_back('{ch: 3'd3, data: 8'hA5});
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 3'd3) begin
      n_fail++; $display("FAIL manual_capture: got v=%b d=%h ch=%0d want v=1 d=a5 ch=3", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_backpressure();
    in_data[3*8 +: 8] = 8'h3C;
    sb.push_back('{ch: 3'd3, data: 8'h3C});
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=a5", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) in_valid = 8'h00;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL bp_sb: got word with empty queue, want none"); end
        else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_ch !== e.ch) begin
            n_fail++; $display("FAIL bp_sb: got ch%0d %h want ch%0d %h", out_ch, out_data, e.ch, e.data);
          end
`ifdef MUX_SCAN_PARITY_EN
          if (out_parity !== ^e.data) begin n_fail++; $display("FAIL bp_parity: got %b want %b", out_parity, ^e.data); end
`endif
        end
      end
      tick();
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got v=%b want 0", out_valid); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_left: got %0d queued want 0", sb.size()); end
  endtask

  task automatic test_out_of_range();
    s_sel = 3'd3; s_sel_load = 1'b1; tick();
    n_checks++; if (s_cur_ch !== 3'd3) begin n_fail++; $display("FAIL oor_load3: got %0d want 3", s_cur_ch); end
    s_sel = 3'd7; tick();
    n_checks++; if (s_cur_ch !== 3'd3) begin n_fail++; $display("FAIL oor_sel7: got %0d want 3", s_cur_ch); end
    s_sel = 3'd6; tick();
    n_checks++; if (s_cur_ch !== 3'd3) begin n_fail++; $display("FAIL oor_sel6: got %0d want 3", s_cur_ch); end
    s_sel = 3'd5; tick();
    s_sel_load = 1'b0;
    n_checks++; if (s_cur_ch !== 3'd5) begin n_fail++; $display("FAIL oor_sel5: got %0d want 5", s_cur_ch); end
  endtask

  task automatic test_scan_all();
    in_valid = 8'h00;
    sel = 3'd0; sel_load = 1'b1; tick();
    sel_load = 1'b0;
    mode = 1'b1; dwell = 4'd4; tick();
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    in_valid = 8'hFF;
    for (int i = 0; i < 10; i++) sb.push_back('{ch: 3'(i % 8), data: 8'h10 + 8'(i % 8)});
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        n_checks++; if (cur_ch !== 3'd2) begin n_fail++; $display("FAIL scan_wrap_ptr: got %0d want 2", cur_ch); end
        in_valid = 8'h00;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL scan_sb: got word with empty queue, want none"); end
        else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_ch !== e.ch) begin
            n_fail++; $display("FAIL scan_sb: got ch%0d %h want ch%0d %h", out_ch, out_data, e.ch, e.data);
          end
        end
      end
      tick();
    end
    n_checks++; if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL scan_drain: got %0d queued v=%b want 0 queued v=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_dwell();
    int n;
    logic [2:0] want;
    mode = 1'b0; tick();
    sel = 3'd0; sel_load = 1'b1; tick();
    sel_load = 1'b0;
    in_data[2*8 +: 8] = 8'h5A;
    mode = 1'b1; dwell = 4'd4; tick();
    in_valid = 8'h04;
    for (int c = 0; c < 2; c++) begin
      n = 0;
      while (cur_ch === 3'(c) && n < 50) begin tick(); n++; end
      n_checks++; if (n != 4) begin n_fail++; $display("FAIL dwell_ch%0d: got %0d cycles want 4", c, n); end
    end
    sb.push_back('{ch: 3'd2, data: 8'h5A});
    n = 0;
    while (cur_ch === 3'd2 && n < 50) begin tick(); n++; end
    n_checks++; if (n != 1 || cur_ch !== 3'd3) begin
      n_fail++; $display("FAIL dwell_capture: got %0d cycles ptr=%0d want 1 cycle ptr=3", n, cur_ch);
    end
    dwell = 4'd0;
    in_valid = 8'h00;
    if (out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL dwell_sb: got word with empty queue, want none"); end
      else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_ch !== e.ch) begin
          n_fail++; $display("FAIL dwell_sb: got ch%0d %h want ch%0d %h", out_ch, out_data, e.ch, e.data);
        end
      end
    end else begin
      n_checks++; n_fail++; $display("FAIL dwell_sb: got v=%b want v=1", out_valid);
    end
    want = 3'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      want = want + 3'd1;
      n_checks++; if (cur_ch !== want) begin n_fail++; $display("FAIL dwell0_skip[%0d]: got %0d want %0d", i, cur_ch, want); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 8'hFF;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got v=%b want 1", out_valid); end
    rst_n = 1'b0; mode = 1'b0; in_valid = 8'h00;
    tick();
    n_checks++; if (out_valid !== 1'b0 || cur_ch !== 3'd0 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL rmid_clear: got v=%b ptr=%0d d=%h want v=0 ptr=0 d=00", out_valid, cur_ch, out_data);
    end
    sb.delete();
    rst_n = 1'b1;
    sel = 3'd5; sel_load = 1'b1; tick();
    sel_load = 1'b0;
    n_checks++; if (cur_ch !== 3'd5) begin n_fail++; $display("FAIL rmid_manual: got %0d want 5", cur_ch); end
  endtask

  task automatic test_parity();
    in_data[5*8 +: 8] = 8'h07;
    in_valid = 8'h20;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h07 || out_ch !== 3'd5) begin
      n_fail++; $display("FAIL par_word: got v=%b d=%h ch=%0d want v=1 d=07 ch=5", out_valid, out_data, out_ch);
    end
`ifdef MUX_SCAN_PARITY_EN
    n_checks++; if (out_parity !== 1'b1) begin n_fail++; $display("FAIL par_bit: got %b want 1", out_parity); end
`endif
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; sel_load = 1'b0;
    dwell = 4'd4; out_ready = 1'b0;
    s_in_data = '0; s_in_valid = '0; s_mode = 1'b0; s_sel = '0; s_sel_load = 1'b0;
    test_reset();
    test_manual();
    test_backpressure();
    test_out_of_range();
    test_scan_all();
    test_dwell();
    test_reset_mid();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised N_CH-channel, W-bit-wide selector with a registered output stage and a valid/ready handshake.
- Two modes:
  - Manual: software-loaded select.
  - Scan: the pointer round-robins through channels, with a dwell timeout that skips idle channels.
- Successor to the team's fixed 8:1 bit mux. Sits between multiple sample sources and a single downstream consumer.

Parameters:
- N_CH, 8, number of input channels (2..64; need not be a power of two).
- W, 8, data width per channel.
- DWELL_W, 4, width of the dwell-timeout counter.
- SEL_W, $clog2(N_CH), select width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  N_CH*W  packed channel data; channel k occupies bits [k*W +: W].
- in_valid  input  N_CH  per-channel data-valid.
- mode  input  1  0 = manual, 1 = scan.
- sel  input  SEL_W  manual channel select.
- sel_load  input  1  one-cycle strobe that loads sel into the pointer.
- dwell  input  DWELL_W  scan dwell limit in cycles; 0 is treated as 1.
- out_data  output  W  registered selected data.
- out_ch  output  SEL_W  channel index of out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  consumer accepts the word.
- cur_ch  output  SEL_W  current pointer value.

Behaviour:
- Reset (rst_n = 0 at a clk edge): out_data = 0, out_ch = 0, out_valid = 0, cur_ch = 0, dwell counter = 0, state = MANUAL.
- Output stage:
  - Capture condition: (!out_valid || out_ready) && in_valid[cur_ch].
  - On capture: out_data <= in_data[cur_ch], out_ch <= cur_ch, out_valid <= 1.
  - Latency is one cycle from in_valid to out_valid.
  - out_valid && out_ready with no new capture: out_valid <= 0.
  - out_data and out_ch hold stable while out_valid && !out_ready.
  - Back-to-back transfers at full rate are supported.
- States and transitions:
  - MANUAL:
    - sel_load with sel < N_CH: cur_ch <= sel.
    - sel_load with sel >= N_CH: ignored, cur_ch unchanged.
    - mode = 1: go to SCAN and clear the dwell counter.
  - SCAN:
    - sel_load is ignored.
    - The dwell counter increments every cycle in which no capture occurs.
    - On capture: cur_ch advances to the next channel and the counter clears.
    - When the counter reaches max(dwell, 1) - 1 without a capture: cur_ch advances and the counter clears (timeout skip).
    - Advancing wraps from N_CH-1 to 0.
    - mode = 0: return to MANUAL and keep cur_ch.
- Simultaneous events:
  - A capture and a timeout in the same cycle count as a single advance.
  - A mode change takes effect the next cycle; a capture in that same cycle still completes.
  - A pending out_valid word is never dropped by a mode change.
- dwell changed mid-count: the new value applies on the next comparison. A counter already past the new limit forces an advance next cycle.
- Reset asserted mid-transfer: the pending word is discarded and out_valid = 0 on the next cycle.

Optional Feature:
- MUX_SCAN_PARITY_EN.
- Defined: adds port out_parity (output, 1 bit) = even parity (XOR) of in_data[cur_ch]. It is registered together with out_data, so its latency is identical. Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package mux_scan_pkg:
  - state enum {MANUAL, SCAN};
  - mode constants MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1.
- Sub-module mux_scan_ptr holds cur_ch, the dwell counter, the wrap logic and the sel_load range check. Its outputs are cur_ch and adv_pulse.
- The top level holds the data slice, the output register, the handshake and the parity option.

Test Plan:
- Reset, then MANUAL: load sel = 3 with in_data channel 3 = 8'hA5 and in_valid = 8'h08 -> next cycle out_valid = 1, out_data = 8'hA5, out_ch = 3.
- Backpressure: out_ready = 0 for 5 cycles while channel 3 changes to 8'h3C -> out_data stays 8'hA5. After out_ready = 1, the next word 8'h3C appears one cycle later.
- Out-of-range load: N_CH = 6, sel_load with sel = 7 -> cur_ch unchanged (3). Then sel = 5 -> cur_ch = 5.
- SCAN with all in_valid = 1 and out_ready = 1 -> out_ch sequence 0, 1, 2 … 7, 0, one word per cycle, wrapping correctly.
- SCAN with dwell = 4 and only channel 2 valid -> channels 0 and 1 each time out after 4 cycles, channel 2 is captured, and cur_ch then advances to 3. With dwell = 0, each empty channel is skipped in 1 cycle.
- rst_n low while out_valid = 1 in SCAN -> next cycle out_valid = 0, cur_ch = 0, state MANUAL. With MUX_SCAN_PARITY_EN, data 8'h07 gives out_parity = 1.
